// File: rtl/vx_fpu_types.sv
// Shared FP types: fflags layout, rounding-mode width, FP CSR addresses,
// CSR op encodings and the field read/modify helpers used by the FCSR unit.
package vx_fpu_types;

   localparam int INST_FRM_BITS = 3;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   typedef enum logic [1:0] {
      CSR_OP_RW = 2'd0,
      CSR_OP_RS = 2'd1,
      CSR_OP_RC = 2'd2,
      CSR_OP_RD = 2'd3
   } csr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_RESP  = 2'd2
   } fcsr_state_e;

   // Unsupported addresses read as zero; every FP CSR fits in the low 8 bits.
   function automatic logic [7:0] csr_read(input logic [INST_FRM_BITS-1:0] frm,
                                           input fflags_t ff,
                                           input logic [11:0] addr);
      case (addr)
         CSR_FFLAGS: return {3'b000, ff};
         CSR_FRM:    return {5'b00000, frm};
         CSR_FCSR:   return {frm, ff};
         default:    return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] csr_modify(input csr_op_e op,
                                             input logic [7:0] old_val,
                                             input logic [7:0] data);
      case (op)
         CSR_OP_RW: return data;
         CSR_OP_RS: return old_val | data;
         CSR_OP_RC: return old_val & ~data;
         default:   return old_val;
      endcase
   endfunction

   function automatic logic is_flag_addr(input logic [11:0] addr);
      return (addr == CSR_FFLAGS) || (addr == CSR_FCSR);
   endfunction

endpackage

// File: rtl/vx_pending_counter.sv
// Per-warp count of in-flight FPU ops: up on issue, down on commit,
// saturating at both ends, with a zero flag for the CSR drain logic.
module vx_pending_counter #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc,
   input  logic dec,
   output logic zero
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (inc && !dec) begin
         if (count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
      end else if (dec && !inc) begin
         if (count_reg != '0) count_reg <= count_reg - 1'b1;
      end
   end

   // Overflow and underflow are clamped in hardware but flag a bookkeeping bug.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(inc && !dec && count_reg == CNT_MAX));
         assert (!(dec && !inc && count_reg == '0));
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/vx_fcsr_unit.sv
// Per-warp FP control/status registers (frm, fflags, fcsr) with a CSR request port.
// Define FCSR_PENDING_STALL_EN to hold fflags/fcsr accesses until the warp's FPU ops drain.
module vx_fcsr_unit
   import vx_fpu_types::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int PEND_W    = 4,
   localparam int NW_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fpu_write_enable,
   input  logic [NW_W-1:0]          fpu_write_wid,
   input  fflags_t                  fpu_write_fflags,
   input  logic [NW_W-1:0]          fpu_read_wid,
   output logic [INST_FRM_BITS-1:0] fpu_read_frm,
   input  logic                     fpu_issue_valid,
   input  logic [NW_W-1:0]          fpu_issue_wid,
   input  logic                     fpu_commit_valid,
   input  logic [NW_W-1:0]          fpu_commit_wid,
   input  logic                     csr_req_valid,
   output logic                     csr_req_ready,
   input  logic [NW_W-1:0]          csr_req_wid,
   input  logic [11:0]              csr_req_addr,
   input  logic [1:0]               csr_req_op,
   input  logic [31:0]              csr_req_data,
   output logic                     csr_rsp_valid,
   input  logic                     csr_rsp_ready,
   output logic [NW_W-1:0]          csr_rsp_wid,
   output logic [31:0]              csr_rsp_data
);

   fcsr_state_e state_reg;
   logic [NW_W-1:0] req_wid_reg;
   logic [11:0]     req_addr_reg;
   csr_op_e         req_op_reg;
   logic [7:0]      req_data_reg;
   logic            rsp_valid_reg;
   logic [NW_W-1:0] rsp_wid_reg;
   logic [31:0]     rsp_data_reg;

   logic [NUM_WARPS-1:0][INST_FRM_BITS-1:0] frm_reg, frm_next;
   fflags_t [NUM_WARPS-1:0]                 fflags_reg, fflags_next;

   logic            need_drain, drain_done, app_en;
   logic [NW_W-1:0] app_wid;
   logic [11:0]     app_addr;
   csr_op_e         app_op;
   logic [7:0]      app_data, old_val, new_val;
   logic            wr_frm, wr_fflags;
   logic            unused_data;

   assign unused_data = ^csr_req_data[31:8];

`ifdef FCSR_PENDING_STALL_EN
   logic [NUM_WARPS-1:0] pend_zero;

   generate
      for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_pend
         logic inc, dec;
         assign inc = fpu_issue_valid  && (fpu_issue_wid  == NW_W'(gi));
         assign dec = fpu_commit_valid && (fpu_commit_wid == NW_W'(gi));
         vx_pending_counter #(.WIDTH(PEND_W)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc),
            .dec     (dec),
            .zero    (pend_zero[gi])
         );
      end
   endgenerate

   assign need_drain = is_flag_addr(csr_req_addr) && !pend_zero[csr_req_wid];
   assign drain_done = (state_reg == ST_DRAIN) && pend_zero[req_wid_reg];
`else
   logic unused_pend;
   assign unused_pend = ^{fpu_issue_valid, fpu_issue_wid, fpu_commit_valid, fpu_commit_wid};
   assign need_drain  = 1'b0;
   assign drain_done  = 1'b0;
`endif

   // In IDLE the op comes straight from the request port; after a drain it comes from the capture.
   always_comb begin
      app_wid  = req_wid_reg;
      app_addr = req_addr_reg;
      app_op   = req_op_reg;
      app_data = req_data_reg;
      if (state_reg == ST_IDLE) begin
         app_wid  = csr_req_wid;
         app_addr = csr_req_addr;
         app_op   = csr_op_e'(csr_req_op);
         app_data = csr_req_data[7:0];
      end
   end

   assign app_en    = (csr_req_valid && (state_reg == ST_IDLE) && !need_drain) || drain_done;
   assign old_val   = csr_read(frm_reg[app_wid], fflags_reg[app_wid], app_addr);
   assign new_val   = csr_modify(app_op, old_val, app_data);
   assign wr_fflags = is_flag_addr(app_addr);
   assign wr_frm    = (app_addr == CSR_FRM) || (app_addr == CSR_FCSR);

   // CSR update lands first so same-cycle FPU exception flags still accumulate on top.
   always_comb begin
      frm_next    = frm_reg;
      fflags_next = fflags_reg;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (app_en && (app_wid == NW_W'(i))) begin
            if (wr_frm)    frm_next[i]    = (app_addr == CSR_FCSR) ? new_val[7:5] : new_val[2:0];
            if (wr_fflags) fflags_next[i] = fflags_t'(new_val[4:0]);
         end
         if (fpu_write_enable && (fpu_write_wid == NW_W'(i)))
            fflags_next[i] = fflags_t'(fflags_next[i] | fpu_write_fflags);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frm_reg    <= '0;
         fflags_reg <= '0;
      end else begin
         frm_reg    <= frm_next;
         fflags_reg <= fflags_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         req_wid_reg   <= '0;
         req_addr_reg  <= '0;
         req_op_reg    <= CSR_OP_RW;
         req_data_reg  <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_wid_reg   <= '0;
         rsp_data_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (csr_req_valid) begin
                  req_wid_reg  <= csr_req_wid;
                  req_addr_reg <= csr_req_addr;
                  req_op_reg   <= csr_op_e'(csr_req_op);
                  req_data_reg <= csr_req_data[7:0];
                  if (need_drain) begin
                     state_reg <= ST_DRAIN;
                  end else begin
                     state_reg     <= ST_RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_wid_reg   <= csr_req_wid;
                     rsp_data_reg  <= {24'h0, old_val};
                  end
               end
            end
`ifdef FCSR_PENDING_STALL_EN
            ST_DRAIN: begin
               if (drain_done) begin
                  state_reg     <= ST_RESP;
                  rsp_valid_reg <= 1'b1;
                  rsp_wid_reg   <= req_wid_reg;
                  rsp_data_reg  <= {24'h0, old_val};
               end
            end
`endif
            ST_RESP: begin
               if (csr_rsp_ready) begin
                  state_reg     <= ST_IDLE;
                  rsp_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               rsp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign fpu_read_frm  = frm_reg[fpu_read_wid];
   assign csr_req_ready = (state_reg == ST_IDLE);
   assign csr_rsp_valid = rsp_valid_reg;
   assign csr_rsp_wid   = rsp_wid_reg;
   assign csr_rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_vx_fcsr_unit.sv
// Self-checking bench for vx_fcsr_unit: directed table, drain/reset sequences,
// and randomized CSR/FPU traffic against a per-warp field model.
module tb_vx_fcsr_unit;

   localparam logic [1:0] OP_RW = 2'd0, OP_RS = 2'd1, OP_RC = 2'd2, OP_RD = 2'd3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fpu_write_enable = 1'b0;
   logic [1:0]  fpu_write_wid = '0;
   logic [4:0]  fpu_write_fflags = '0;
   logic [1:0]  fpu_read_wid = '0;
   logic [2:0]  fpu_read_frm;
   logic        fpu_issue_valid = 1'b0;
   logic [1:0]  fpu_issue_wid = '0;
   logic        fpu_commit_valid = 1'b0;
   logic [1:0]  fpu_commit_wid = '0;
   logic        csr_req_valid = 1'b0;
   logic        csr_req_ready;
   logic [1:0]  csr_req_wid = '0;
   logic [11:0] csr_req_addr = '0;
   logic [1:0]  csr_req_op = '0;
   logic [31:0] csr_req_data = '0;
   logic        csr_rsp_valid;
   logic        csr_rsp_ready = 1'b0;
   logic [1:0]  csr_rsp_wid;
   logic [31:0] csr_rsp_data;

   int checks = 0;
   int failures = 0;

   logic [2:0] frm_m [4];
   logic [4:0] ff_m  [4];

   typedef struct {
      logic        pre_en;
      logic [1:0]  pre_wid;
      logic [4:0]  pre_ff;
      logic [1:0]  wid;
      logic [11:0] addr;
      logic [1:0]  op;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];

   vx_fcsr_unit #(.NUM_WARPS(4), .PEND_W(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .fpu_write_enable (fpu_write_enable),
      .fpu_write_wid    (fpu_write_wid),
      .fpu_write_fflags (fpu_write_fflags),
      .fpu_read_wid     (fpu_read_wid),
      .fpu_read_frm     (fpu_read_frm),
      .fpu_issue_valid  (fpu_issue_valid),
      .fpu_issue_wid    (fpu_issue_wid),
      .fpu_commit_valid (fpu_commit_valid),
      .fpu_commit_wid   (fpu_commit_wid),
      .csr_req_valid    (csr_req_valid),
      .csr_req_ready    (csr_req_ready),
      .csr_req_wid      (csr_req_wid),
      .csr_req_addr     (csr_req_addr),
      .csr_req_op       (csr_req_op),
      .csr_req_data     (csr_req_data),
      .csr_rsp_valid    (csr_rsp_valid),
      .csr_rsp_ready    (csr_rsp_ready),
      .csr_rsp_wid      (csr_rsp_wid),
      .csr_rsp_data     (csr_rsp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input int w, input logic [11:0] a);
      case (a)
         12'h001: return {27'h0, ff_m[w]};
         12'h002: return {29'h0, frm_m[w]};
         12'h003: return {24'h0, frm_m[w], ff_m[w]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic void m_write(input int w, input logic [11:0] a,
                                   input logic [1:0] op, input logic [31:0] d);
      logic [31:0] o, n;
      o = m_read(w, a);
      case (op)
         OP_RW:   n = d;
         OP_RS:   n = o | d;
         OP_RC:   n = o & ~d;
         default: n = o;
      endcase
      if (a == 12'h001) ff_m[w] = n[4:0];
      else if (a == 12'h002) frm_m[w] = n[2:0];
      else if (a == 12'h003) begin
         frm_m[w] = n[7:5];
         ff_m[w]  = n[4:0];
      end
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) begin
         frm_m[i] = '0;
         ff_m[i]  = '0;
      end
   endfunction

   task automatic fpu_wr(input logic [1:0] w, input logic [4:0] f);
      fpu_write_enable = 1'b1;
      fpu_write_wid    = w;
      fpu_write_fflags = f;
      tick();
      fpu_write_enable = 1'b0;
      ff_m[w] = ff_m[w] | f;
   endtask

   task automatic rsp_handshake();
      csr_rsp_ready = 1'b1;
      tick();
      csr_rsp_ready = 1'b0;
      chk("ready_after_rsp", {31'h0, csr_req_ready}, 32'h1);
      chk("valid_after_rsp", {31'h0, csr_rsp_valid}, 32'h0);
   endtask

   // One non-draining CSR access, optionally with a same-cycle FPU flag write.
   task automatic txn(input logic [1:0] w, input logic [11:0] a, input logic [1:0] op,
                      input logic [31:0] d, input logic fe, input logic [1:0] fw,
                      input logic [4:0] ff, input int hold, output logic [31:0] rsp);
      logic [31:0] exp;
      int waited;
      exp = m_read(w, a);
      chk("req_ready_idle", {31'h0, csr_req_ready}, 32'h1);
      csr_req_valid    = 1'b1;
      csr_req_wid      = w;
      csr_req_addr     = a;
      csr_req_op       = op;
      csr_req_data     = d;
      fpu_write_enable = fe;
      fpu_write_wid    = fw;
      fpu_write_fflags = ff;
      tick();
      csr_req_valid    = 1'b0;
      fpu_write_enable = 1'b0;
      m_write(w, a, op, d);
      if (fe) ff_m[fw] = ff_m[fw] | ff;
      chk("rsp_latency1", {31'h0, csr_rsp_valid}, 32'h1);
      waited = 0;
      while (!csr_rsp_valid && waited < 20) begin
         tick();
         waited++;
      end
      if (!csr_rsp_valid) chk("rsp_timeout", {31'h0, csr_rsp_valid}, 32'h1);
      fpu_read_wid = w;
      #1;
      chk("frm_visible", {29'h0, fpu_read_frm}, {29'h0, frm_m[w]});
      chk("rsp_data", csr_rsp_data, exp);
      chk("rsp_wid", {30'h0, csr_rsp_wid}, {30'h0, w});
      rsp = csr_rsp_data;
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("hold_valid", {31'h0, csr_rsp_valid}, 32'h1);
         chk("hold_data", csr_rsp_data, exp);
         chk("hold_wid", {30'h0, csr_rsp_wid}, {30'h0, w});
      end
      rsp_handshake();
      $display("txn w=%0d addr=%03h op=%0d data=%08h fpu=%0d/%0d/%02h rsp=%08h exp=%08h",
               w, a, op, d, fe, fw, ff, rsp, exp);
   endtask

   initial begin
      logic [31:0] rsp;
      m_reset();

      // Reset state
      tick();
      chk("rst_rsp_valid", {31'h0, csr_rsp_valid}, 32'h0);
      chk("rst_rsp_data", csr_rsp_data, 32'h0);
      chk("rst_rsp_wid", {30'h0, csr_rsp_wid}, 32'h0);
      chk("rst_req_ready", {31'h0, csr_req_ready}, 32'h1);
      chk("rst_frm", {29'h0, fpu_read_frm}, 32'h0);
      reset_n = 1'b1;
      tick();

      //            pre_en pre_w pre_ff wid addr     op     data           exp
      vecs[0]  = '{1'b0, 2'd0, 5'h00, 2'd0, 12'h003, OP_RD, 32'h0,        32'h00};
      vecs[1]  = '{1'b1, 2'd1, 5'h01, 2'd0, 12'h001, OP_RD, 32'h0,        32'h00};
      vecs[2]  = '{1'b1, 2'd1, 5'h10, 2'd1, 12'h001, OP_RD, 32'h0,        32'h11};
      vecs[3]  = '{1'b0, 2'd0, 5'h00, 2'd2, 12'h002, OP_RW, 32'h3,        32'h00};
      vecs[4]  = '{1'b0, 2'd0, 5'h00, 2'd2, 12'h003, OP_RC, 32'hFF,       32'h60};
      vecs[5]  = '{1'b0, 2'd0, 5'h00, 2'd2, 12'h003, OP_RD, 32'h0,        32'h00};
      vecs[6]  = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h003, OP_RS, 32'hE5,       32'h11};
      vecs[7]  = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h003, OP_RD, 32'h0,        32'hF5};
      vecs[8]  = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h001, OP_RW, 32'h3FF,      32'h15};
      vecs[9]  = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h003, OP_RD, 32'h0,        32'hFF};
      vecs[10] = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h002, OP_RC, 32'h5,        32'h07};
      vecs[11] = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h003, OP_RD, 32'h0,        32'h5F};
      vecs[12] = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h004, OP_RW, 32'hFF,       32'h00};
      vecs[13] = '{1'b0, 2'd0, 5'h00, 2'd1, 12'h003, OP_RD, 32'h0,        32'h5F};
      vecs[14] = '{1'b0, 2'd0, 5'h00, 2'd3, 12'h002, OP_RS, 32'hFFFFFFFC, 32'h00};
      vecs[15] = '{1'b0, 2'd0, 5'h00, 2'd3, 12'h002, OP_RD, 32'h0,        32'h04};
      vecs[16] = '{1'b0, 2'd0, 5'h00, 2'd0, 12'h000, OP_RW, 32'h1,        32'h00};
      vecs[17] = '{1'b0, 2'd0, 5'h00, 2'd0, 12'h003, OP_RD, 32'h0,        32'h00};

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].pre_en) fpu_wr(vecs[i].pre_wid, vecs[i].pre_ff);
         txn(vecs[i].wid, vecs[i].addr, vecs[i].op, vecs[i].data, 1'b0, 2'd0, 5'h0, 0, rsp);
         chk($sformatf("vec%0d_rsp", i), rsp, vecs[i].exp);
      end

      // Same-cycle RS and FPU write on warp 0, response held five cycles
      txn(2'd0, 12'h001, OP_RS, 32'h04, 1'b1, 2'd0, 5'h08, 5, rsp);
      txn(2'd0, 12'h001, OP_RD, 32'h0, 1'b0, 2'd0, 5'h00, 0, rsp);
      chk("rs_plus_fpu", rsp, 32'h0C);
      // RW must not wipe out a same-cycle FPU flag
      txn(2'd0, 12'h001, OP_RW, 32'h01, 1'b1, 2'd0, 5'h02, 0, rsp);
      txn(2'd0, 12'h001, OP_RD, 32'h0, 1'b0, 2'd0, 5'h00, 0, rsp);
      chk("rw_then_fpu", rsp, 32'h03);
      txn(2'd0, 12'h001, OP_RW, 32'h00, 1'b1, 2'd3, 5'h01, 0, rsp);

      // Issue and commit on the same warp in one cycle leave it idle
      fpu_issue_valid = 1'b1;  fpu_issue_wid = 2'd0;
      fpu_commit_valid = 1'b1; fpu_commit_wid = 2'd0;
      tick();
      fpu_issue_valid = 1'b0;  fpu_commit_valid = 1'b0;
      txn(2'd0, 12'h003, OP_RD, 32'h0, 1'b0, 2'd0, 5'h00, 0, rsp);

      // Drain: two ops outstanding on warp 3
      fpu_issue_valid = 1'b1; fpu_issue_wid = 2'd3;
      tick(); tick();
      fpu_issue_valid = 1'b0;
      chk("drain_req_ready", {31'h0, csr_req_ready}, 32'h1);
      csr_req_valid = 1'b1; csr_req_wid = 2'd3; csr_req_addr = 12'h001;
      csr_req_op = OP_RD; csr_req_data = 32'h0;
      tick();
      csr_req_valid = 1'b0;
`ifdef FCSR_PENDING_STALL_EN
      for (int k = 0; k < 2; k++) begin
         chk("drain_ready_low", {31'h0, csr_req_ready}, 32'h0);
         chk("drain_no_rsp", {31'h0, csr_rsp_valid}, 32'h0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         fpu_commit_valid = 1'b1; fpu_commit_wid = 2'd3;
         tick();
         fpu_commit_valid = 1'b0;
         chk("drain_commit_no_rsp", {31'h0, csr_rsp_valid}, 32'h0);
      end
      tick();
`else
      for (int k = 0; k < 2; k++) begin
         fpu_commit_valid = 1'b1; fpu_commit_wid = 2'd3;
         if (k == 0) chk("nodrain_rsp", {31'h0, csr_rsp_valid}, 32'h1);
         tick();
         fpu_commit_valid = 1'b0;
      end
`endif
      chk("drain_rsp_valid", {31'h0, csr_rsp_valid}, 32'h1);
      chk("drain_rsp_data", csr_rsp_data, {27'h0, ff_m[3]});
      chk("drain_rsp_wid", {30'h0, csr_rsp_wid}, 32'h3);
      $display("txn w=3 addr=001 op=3 drained rsp=%08h", csr_rsp_data);
      rsp_handshake();

      // Reset with a request in flight (draining when the stall feature is built in)
      fpu_issue_valid = 1'b1; fpu_issue_wid = 2'd2;
      tick();
      fpu_issue_valid = 1'b0;
      csr_req_valid = 1'b1; csr_req_wid = 2'd2; csr_req_addr = 12'h003;
      csr_req_op = OP_RW; csr_req_data = 32'hFF;
      tick();
      csr_req_valid = 1'b0;
      tick();
      chk("inflight_busy", {31'h0, csr_req_ready}, 32'h0);
      reset_n = 1'b0;
      #1;
      chk("rst2_rsp_valid", {31'h0, csr_rsp_valid}, 32'h0);
      chk("rst2_req_ready", {31'h0, csr_req_ready}, 32'h1);
      chk("rst2_rsp_data", csr_rsp_data, 32'h0);
      tick();
      reset_n = 1'b1;
      m_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst2_no_rsp", {31'h0, csr_rsp_valid}, 32'h0);
      end
      for (int w = 0; w < 4; w++) begin
         txn(2'(w), 12'h003, OP_RD, 32'h0, 1'b0, 2'd0, 5'h00, 0, rsp);
         chk("rst2_fcsr_zero", rsp, 32'h0);
      end

      // Randomized traffic against the field model
      for (int it = 0; it < 250; it++) begin
         logic [1:0]  w, fw;
         logic [11:0] a;
         logic [4:0]  ff;
         int          sel, ai;
         w  = 2'($urandom_range(0, 3));
         fw = 2'($urandom_range(0, 3));
         ff = 5'($urandom());
         sel = $urandom_range(0, 3);
         ai = $urandom_range(0, 5);
         if (ai <= 3) a = 12'(ai);
         else if (ai == 4) a = 12'h003;
         else a = 12'($urandom_range(4, 4095));
         if (sel == 0) begin
            fpu_wr(fw, ff);
         end else begin
            txn(w, a, 2'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)),
                fw, ff, $urandom_range(0, 2), rsp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vx_fcsr_unit.md
VX_FCSR_UNIT -- requirements
Module: VX_fcsr_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps holding FP control state.
REQ-002 SHALL have parameter PEND_W, default 4, width of each per-warp pending-FPU-op counter.
REQ-003 SHALL have localparam NW_W = max(1, clog2(NUM_WARPS)), the warp-id width.
REQ-004 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have fpu_write_enable  in  1  FPU reports exception flags this cycle.
REQ-007 SHALL have fpu_write_wid  in  NW_W  warp owning the reported flags.
REQ-008 SHALL have fpu_write_fflags  in  5  {NV,DZ,OF,UF,NX} flags to accumulate.
REQ-009 SHALL have fpu_read_wid  in  NW_W  warp whose rounding mode the FPU needs.
REQ-010 SHALL have fpu_read_frm  out  3  rounding mode of fpu_read_wid.
REQ-011 SHALL have fpu_issue_valid / fpu_issue_wid  in  1 / NW_W  FPU op issued for warp.
REQ-012 SHALL have fpu_commit_valid / fpu_commit_wid  in  1 / NW_W  FPU op retired for warp.
REQ-013 SHALL have csr_req_valid  in  1; csr_req_ready  out  1  CSR request handshake.
REQ-014 SHALL have csr_req_wid  in  NW_W; csr_req_addr  in  12; csr_req_op  in  2 (0=RW,1=RS,2=RC,3=RD); csr_req_data  in  32.
REQ-015 SHALL have csr_rsp_valid  out  1; csr_rsp_ready  in  1; csr_rsp_wid  out  NW_W; csr_rsp_data  out  32  old CSR value.

Function
REQ-016 SHALL hold per warp frm[2:0] and fflags[4:0]; fcsr (0x003) = {24'b0, frm, fflags}, fflags (0x001), frm (0x002).
REQ-017 SHALL drive fpu_read_frm combinationally from frm[fpu_read_wid]; a CSR frm write becomes visible the cycle after it is applied.
REQ-018 SHALL OR fpu_write_fflags into fflags[fpu_write_wid] each cycle fpu_write_enable=1 (sticky).
REQ-019 SHALL run FSM IDLE -> (DRAIN | RESP) -> IDLE; csr_req_ready = (state==IDLE).
REQ-020 SHALL, on accept in IDLE, capture wid/addr/op/data and go to DRAIN if addr is 0x001/0x003 and pend[wid]!=0, else apply the op and go to RESP.
REQ-021 SHALL stay in DRAIN until pend[wid]==0, then apply the op and enter RESP the next cycle.
REQ-022 SHALL apply RW: reg=data; RS: reg|=data; RC: reg&=~data; RD: no change; only the addressed field bits are written; csr_rsp_data = pre-update value.
REQ-023 SHALL, with no drain, assert csr_rsp_valid exactly one cycle after the accept cycle.
REQ-024 SHALL hold csr_rsp_valid, csr_rsp_wid and csr_rsp_data stable until csr_rsp_ready=1, then return to IDLE the same edge.
REQ-025 SHALL, for an unsupported address, respond with data 0 and change no state.
REQ-026 SHALL, when a CSR update and fpu_write_enable hit the same warp in one cycle, apply the CSR op first and OR the FPU flags on top.
REQ-027 SHALL increment pend on issue and decrement on commit; issue and commit to the same warp in one cycle leave it unchanged.
REQ-028 SHALL saturate pend at 2^PEND_W-1 on issue and hold 0 on commit-at-zero; both SHALL fire a simulation assertion.

Reset
REQ-029 SHALL, while reset_n=0, force frm=0 (RNE), fflags=0, pend=0, state=IDLE, csr_rsp_valid=0, csr_rsp_data=0, csr_rsp_wid=0.
REQ-030 SHALL abandon any in-flight CSR request on reset with no state update and no response.

Configuration
REQ-031 SHALL, with FCSR_PENDING_STALL_EN defined, implement pend counters and the DRAIN state.
REQ-032 SHALL, without FCSR_PENDING_STALL_EN, omit counters and DRAIN; fpu_issue_*/fpu_commit_* are ignored and every request goes IDLE -> RESP.

Structure
REQ-033 SHALL take fflags_t, INST_FRM_BITS, the CSR addresses and csr_req_op encodings from the shared VX_fpu_types package.
REQ-034 SHALL implement each per-warp counter as sub-module VX_pending_counter (up/down, saturating, zero flag), instantiated NUM_WARPS times.

Verification
REQ-035 SHALL check: reset, then RD 0x003 warp 0 -> rsp_data 0x00 one cycle after accept.
REQ-036 SHALL check: fpu_write fflags 0x01 then 0x10 to warp 1, RD 0x001 warp 1 -> 0x11; warp 0 still 0x00.
REQ-037 SHALL check: RW frm=0x3 on warp 2, next cycle fpu_read_wid=2 -> fpu_read_frm=3; RC 0x003 data 0xFF -> rsp 0x60, fcsr then 0x00.
REQ-038 SHALL check: 2 issues to warp 3, RD 0x001 warp 3 -> csr_req_ready low, no rsp until 2nd commit, rsp the cycle after pend hits 0.
REQ-039 SHALL check: RS 0x001 data 0x04 and fpu_write 0x08 same cycle, warp 0 from 0 -> final fflags 0x0C; rsp held 5 cycles with rsp_ready=0 stays stable.
REQ-040 SHALL check: reset_n asserted while in DRAIN -> csr_rsp_valid=0, state IDLE, all fcsr 0.
